// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data memory controller and its RAM.
package mem_pkg;

  // Access size encodings carried on req_size (3 is reserved and flagged as an error)
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  // Controller FSM states
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } mem_state_t;

  // Byte-lane write strobes for a store of the given size at the given lane.
  // Lane 0 is bits 7:0 (little-endian). Halfwords use lane[1] to pick the pair.
  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      MEM_BYTE: strb = 4'b0001 << lane;
      MEM_HALF: strb = lane[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: strb = 4'b1111;
      default:  strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/mem_ram_be.sv
// DEPTH x 32 synchronous single-port RAM with per-byte write enables and a
// registered read port. The read register only updates when re is high, so the
// last read value is held between loads.
module mem_ram_be #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write and registered read on the same address
  // NOTE: the array and its read register have no reset; clearing the contents is
  // the controller's clear engine's job, which keeps this mappable onto SRAM macros.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller for the MIPS MEM stage: valid/ready request port,
// byte/half/word access with sign or zero extension, alignment and range error
// reporting, 1-cycle load latency and a sequential clear engine.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error
);

  localparam int AW = $clog2(DEPTH);
  localparam mem_state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  mem_state_t    state;
  logic [AW-1:0] clr_ptr;

  logic          accept;
  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;

  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic          ram_re;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  // Per-request context kept for the response cycle; only updated on accept
  logic          p_load;
  logic          p_err;
  logic [1:0]    p_size;
  logic          p_unsigned;
  logic [1:0]    p_lane;
  logic [31:0]   shifted;

  assign word_idx = req_addr[AW+1:2];
  assign lane     = req_addr[1:0];
  assign busy     = (state == ST_CLEAR);
  // rst gates ready so a CLEAR_ON_RESET=0 build still shows not-ready while held in reset
  assign req_ready = rst && (state == ST_IDLE) && !clear_req;
  assign accept    = req_valid && req_ready;
  assign resp_error = p_err;

  // Request decode: reserved size, misalignment and out-of-range byte address
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'd3) req_err = 1'b1;
    if (req_size == MEM_HALF && req_addr[0]) req_err = 1'b1;
    if (req_size == MEM_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ((req_addr >> (AW + 2)) != '0) req_err = 1'b1;
  end

  // RAM port steering: the clear engine owns the port while busy
  always_comb begin
    ram_addr  = word_idx;
    ram_we    = 4'b0000;
    ram_re    = 1'b0;
    ram_wdata = req_wdata;
    if (state == ST_CLEAR) begin
      ram_addr  = clr_ptr;
      ram_we    = 4'b1111;
      ram_wdata = '0;
    end else if (accept && !req_err) begin
      if (req_write) begin
        ram_we = lane_strobe(req_size, lane);
        case (req_size)
          MEM_BYTE: ram_wdata = {4{req_wdata[7:0]}};
          MEM_HALF: ram_wdata = {2{req_wdata[15:0]}};
          default:  ram_wdata = req_wdata;
        endcase
      end else begin
        ram_re = 1'b1;
      end
    end
  end

  mem_ram_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .re    (ram_re),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Clear engine / mode FSM: one word zeroed per cycle, DEPTH cycles total
  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RESET_STATE;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == AW'(DEPTH - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (clear_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response pipeline: one resp_valid pulse per accepted request, latency 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      p_load     <= 1'b0;
      p_err      <= 1'b0;
      p_size     <= MEM_WORD;
      p_unsigned <= 1'b0;
      p_lane     <= 2'b00;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        p_load     <= !req_write && !req_err;
        p_err      <= req_err;
        p_size     <= req_size;
        p_unsigned <= req_unsigned;
        p_lane     <= lane;
      end
    end
  end

  // Load result: shift the addressed lane down and extend; zero for stores and errors
  always_comb begin
    shifted    = ram_rdata >> {p_lane, 3'b000};
    resp_rdata = '0;
    if (p_load) begin
      case (p_size)
        MEM_BYTE: resp_rdata = p_unsigned ? {24'd0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
        MEM_HALF: resp_rdata = p_unsigned ? {16'd0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
        default:  resp_rdata = shifted;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl with DEPTH = 16, CLEAR_ON_RESET = 1.
module tb_data_memory_ctrl;

  localparam int DEPTH = 16;
  localparam int NVEC  = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear_req = 1'b0;
  logic        busy;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  data_memory_ctrl #(
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (32),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_req    (clear_req),
    .busy         (busy),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},       {31'd0, busy},       32'd1);
    check({tag, " req_ready"},  {31'd0, req_ready},  32'd0);
    check({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, " resp_rdata"}, resp_rdata,          32'd0);
    check({tag, " resp_error"}, {31'd0, resp_error}, 32'd0);
  endtask

  // Counts clock edges until busy drops (bounded); optionally pulses clear_req mid-run
  task automatic count_clear(input string tag, input bit poke_clear, output int cycles);
    logic ready_seen;
    cycles = 0;
    ready_seen = 1'b0;
    while (busy && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      clear_req = poke_clear && (cycles == 8);
      if (busy) ready_seen = ready_seen | req_ready;
    end
    clear_req = 1'b0;
    check({tag, " clear cycles"}, 32'(cycles), 32'(DEPTH));
    check({tag, " ready during clear"}, {31'd0, ready_seen}, 32'd0);
  endtask

  // One request presented for one cycle; response checked right after the accept edge
  task automatic do_req(input string name, input vec_t v);
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    #1;
    check({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    check({name, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({name, " resp_rdata"}, resp_rdata, v.exp_rdata);
    check({name, " resp_error"}, {31'd0, resp_error}, {31'd0, v.exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cycles;
    vec_t rd;

    //               wr    size  uns   addr       wdata          exp_rdata      err
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 32'h3C, 32'h55AA_55AA, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0000_0000, 32'h55AA_55AA, 1'b0};
    vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'h8000_00F1, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h08, 32'h0000_0000, 32'hFFFF_FFF1, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h08, 32'h0000_0000, 32'h0000_00F1, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0A, 32'h0000_0000, 32'hFFFF_8000, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0000_0000, 32'h0000_8000, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h05, 32'h1234_56AA, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h06, 32'hFFFF_1234, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0000_0000, 32'h1234_AA00, 1'b0};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h04, 32'h0000_0000, 32'hFFFF_AA00, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h07, 32'h0000_0000, 32'h0000_0012, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h06, 32'h0000_0000, 32'h0000_0034, 1'b0};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h02, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b1, 2'd1, 1'b0, 32'h03, 32'h0000_BEEF, 32'h0000_0000, 1'b1};
    vecs[16] = '{1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_BABE, 32'h0000_0000, 1'b1};
    vecs[17] = '{1'b1, 2'd3, 1'b0, 32'h0C, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[18] = '{1'b0, 2'd3, 1'b1, 32'h00, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[19] = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[20] = '{1'b0, 2'd2, 1'b0, 32'h0C, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[21] = '{1'b0, 2'd2, 1'b1, 32'h08, 32'h0000_0000, 32'h8000_00F1, 1'b0};

    // Reset state, then the post-reset clear (a clear_req mid-clear must be ignored)
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    count_clear("power-on", 1'b1, cycles);

    // Table: back-to-back accepts, one response per cycle
    for (int i = 0; i < NVEC; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i]);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle resp_valid", {31'd0, resp_valid}, 32'd0);
    check("hold resp_rdata", resp_rdata, 32'h8000_00F1);
    check("hold resp_error", {31'd0, resp_error}, 32'd0);

    // clear_req with a pending request: request refused, clear starts
    clear_req = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h08;
    #1;
    check("clear_req blocks ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    req_valid = 1'b0;
    check("clear no resp", {31'd0, resp_valid}, 32'd0);
    check("clear busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    check("clear busy at cycle 5", {31'd0, busy}, 32'd1);

    // Reset in the middle of the clear: full rerun from word 0
    rst = 1'b0;
    #2;
    check_reset_outputs("mid-clear reset");
    @(negedge clk);
    rst = 1'b1;
    count_clear("restart", 1'b0, cycles);

    // Every word reads back as zero
    for (int w = 0; w < DEPTH; w++) begin
      rd = '{1'b0, 2'd2, 1'b0, 32'(w * 4), 32'h0, 32'h0, 1'b0};
      do_req($sformatf("cleared word%0d", w), rd);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
